// File: rtl/debug_uart_tx.sv
// Serialises the CPU debug value over a UART 8N1 line as SYNC + MSB-first data bytes.
// Define DEBUG_UART_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         DATA_W       = 64,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] debug_in,
  input  logic              send_req,
  output logic              tx,
  output logic              busy,
  output logic              pending,
  output logic [15:0]       frames_sent
);

  localparam int NUM_DATA = DATA_W / 8;
`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int NUM_BYTES = NUM_DATA + 2;
`else
  localparam int NUM_BYTES = NUM_DATA + 1;
`endif
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(NUM_BYTES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]        state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_idx_reg;
  logic [BYTE_W-1:0] byte_idx_reg;
  logic [7:0]        cur_byte_reg;
  logic [DATA_W-1:0] data_sr_reg;
  logic [DATA_W-1:0] last_sent_reg;
  logic [DATA_W-1:0] queued_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              pending_reg;
  logic [15:0]       frames_sent_reg;

  logic              trig;
  logic              baud_done;
  logic              gap_done;
  logic              start_frame;
  logic [DATA_W-1:0] frame_value;

`ifdef DEBUG_UART_CHECKSUM_EN
  localparam logic [BYTE_W-1:0] DATA_LAST = BYTE_W'(NUM_DATA);
  logic [7:0] csum_reg;

  function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NUM_DATA; i++) acc = acc ^ v[i*8 +: 8];
    return acc;
  endfunction
`endif

  assign trig      = send_req || (debug_in != last_sent_reg);
  assign baud_done = (baud_reg == BAUD_LAST);
  assign gap_done  = (state_reg == ST_GAP) && baud_done;
  // A frame starts from IDLE on a trigger, or straight out of the gap when work is waiting.
  assign start_frame = ((state_reg == ST_IDLE) && trig) || (gap_done && (trig || pending_reg));
  // A fresh trigger always beats the queued value: newest wins.
  assign frame_value = trig ? debug_in : queued_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      baud_reg        <= '0;
      bit_idx_reg     <= '0;
      byte_idx_reg    <= '0;
      cur_byte_reg    <= '0;
      data_sr_reg     <= '0;
      last_sent_reg   <= '0;
      queued_reg      <= '0;
      tx_reg          <= 1'b1;
      busy_reg        <= 1'b0;
      pending_reg     <= 1'b0;
      frames_sent_reg <= '0;
`ifdef DEBUG_UART_CHECKSUM_EN
      csum_reg        <= '0;
`endif
    end else begin
      if (gap_done) frames_sent_reg <= frames_sent_reg + 16'd1;

      if (start_frame) begin
        last_sent_reg <= frame_value;
        data_sr_reg   <= frame_value;
`ifdef DEBUG_UART_CHECKSUM_EN
        csum_reg      <= xor_bytes(frame_value);
`endif
        cur_byte_reg  <= SYNC_BYTE;
        byte_idx_reg  <= '0;
        bit_idx_reg   <= '0;
        baud_reg      <= '0;
        state_reg     <= ST_START;
        tx_reg        <= 1'b0;
        busy_reg      <= 1'b1;
        pending_reg   <= 1'b0;
      end else begin
        if (trig && (state_reg != ST_IDLE)) begin
          pending_reg <= 1'b1;
          queued_reg  <= debug_in;
        end

        if (state_reg != ST_IDLE) baud_reg <= baud_done ? '0 : baud_reg + BAUD_W'(1);

        case (state_reg)
          ST_IDLE: ;
          ST_START: begin
            if (baud_done) begin
              state_reg <= ST_DATA;
              tx_reg    <= cur_byte_reg[0];
            end
          end
          ST_DATA: begin
            if (baud_done) begin
              if (bit_idx_reg == 3'd7) begin
                state_reg   <= ST_STOP;
                bit_idx_reg <= '0;
                tx_reg      <= 1'b1;
              end else begin
                bit_idx_reg  <= bit_idx_reg + 3'd1;
                tx_reg       <= cur_byte_reg[1];
                cur_byte_reg <= {1'b0, cur_byte_reg[7:1]};
              end
            end
          end
          ST_STOP: begin
            if (baud_done) begin
              if (byte_idx_reg == BYTE_LAST) begin
                state_reg <= ST_GAP;
              end else begin
                byte_idx_reg <= byte_idx_reg + BYTE_W'(1);
                state_reg    <= ST_START;
                tx_reg       <= 1'b0;
`ifdef DEBUG_UART_CHECKSUM_EN
                if (byte_idx_reg == DATA_LAST) begin
                  cur_byte_reg <= csum_reg;
                end else begin
                  cur_byte_reg <= data_sr_reg[DATA_W-1 -: 8];
                  data_sr_reg  <= data_sr_reg << 8;
                end
`else
                cur_byte_reg <= data_sr_reg[DATA_W-1 -: 8];
                data_sr_reg  <= data_sr_reg << 8;
`endif
              end
            end
          end
          ST_GAP: begin
            if (baud_done) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx          = tx_reg;
  assign busy        = busy_reg;
  assign pending     = pending_reg;
  assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Randomised bench for debug_uart_tx: a timer-based frame model predicts tx, busy,
// pending and frames_sent every cycle; directed steps cover the main scenarios.
module tb_debug_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 64;
`ifdef DEBUG_UART_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int FRAME_CYC = (NB * 10 + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          send_req = 1'b0;
  logic [DW-1:0] debug_in = '0;
  logic          tx, busy, pending;
  logic [15:0]   frames_sent;

  debug_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .debug_in   (debug_in),
    .send_req   (send_req),
    .tx         (tx),
    .busy       (busy),
    .pending    (pending),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Byte i of the frame: 0 = sync, 1..8 = data MSB first, 9 = XOR checksum.
  function automatic logic [7:0] frame_byte(input logic [63:0] v, input int i);
    logic [7:0] acc;
    if (i == 0) return 8'hA5;
    if (i <= 8) return v[(8 - i) * 8 +: 8];
    acc = 8'h00;
    for (int k = 0; k < 8; k++) acc = acc ^ v[k * 8 +: 8];
    return acc;
  endfunction

  // Line level at cycle offset k into a frame, gap included.
  function automatic logic exp_bit(input logic [63:0] v, input int k);
    int bitpos, byte_i, b;
    logic [7:0] byt;
    bitpos = k / CPB;
    byte_i = bitpos / 10;
    b      = bitpos % 10;
    if (byte_i >= NB) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    byt = frame_byte(v, byte_i);
    return byt[b - 1];
  endfunction

  logic        m_busy, m_pend;
  logic [63:0] m_last, m_queued, m_val;
  logic [15:0] m_frames;
  longint      m_start;
  longint      cyc = 0;

  task automatic model_capture(input logic [63:0] v);
    m_last  = v;
    m_val   = v;
    m_start = cyc;
    m_busy  = 1'b1;
    m_pend  = 1'b0;
  endtask

  task automatic step();
    logic trig;
    logic exp_tx;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_pend = 1'b0; m_last = '0; m_frames = '0;
    end else begin
      trig = send_req || (debug_in != m_last);
      if (m_busy && (cyc - m_start == FRAME_CYC)) begin
        m_frames = m_frames + 16'd1;
        $display("frame %0d done value=%h at cycle %0d", m_frames, m_val, cyc);
        if (trig) model_capture(debug_in);
        else if (m_pend) model_capture(m_queued);
        else m_busy = 1'b0;
      end else if (m_busy) begin
        if (trig) begin
          m_pend   = 1'b1;
          m_queued = debug_in;
        end
      end else if (trig) begin
        model_capture(debug_in);
      end
    end
    exp_tx = m_busy ? exp_bit(m_val, int'(cyc - m_start)) : 1'b1;
    #1;
    check("tx", 64'(tx), 64'(exp_tx));
    check("busy", 64'(busy), 64'(m_busy));
    check("pending", 64'(pending), 64'(m_pend));
    check("frames_sent", 64'(frames_sent), 64'(m_frames));
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_frames(input logic [15:0] n, input int budget);
    int k;
    k = 0;
    while (frames_sent !== n && k < budget) begin
      step();
      k++;
    end
    check("frames_reach", 64'(frames_sent), 64'(n));
  endtask

  initial begin
    logic [63:0] prev;
    m_busy = 1'b0; m_pend = 1'b0; m_last = '0; m_queued = '0; m_val = '0;
    m_frames = '0; m_start = 0;

    rst = 1'b1;
    run(3);
    rst = 1'b0;
    debug_in = '0;
    run(200);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_frames", 64'(frames_sent), 64'd0);
    check("idle_tx", 64'(tx), 64'd1);

    debug_in = 64'd3;
    step();
    check("start_bit", 64'(tx), 64'd0);
    run(100);
    debug_in = 64'd15;
    run(50);
    debug_in = 64'd40;
    step();
    check("pending_set", 64'(pending), 64'd1);
    run_until_frames(16'd1, 2 * FRAME_CYC);
    check("no_busy_drop", 64'(busy), 64'd1);
    check("pending_clear", 64'(pending), 64'd0);
    run_until_frames(16'd2, 2 * FRAME_CYC);
    check("idle_after_two", 64'(busy), 64'd0);

    run(20);
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    check("resend_busy", 64'(busy), 64'd1);
    run_until_frames(16'd3, 2 * FRAME_CYC);

    run(10);
    debug_in = 64'hDEAD_BEEF_CAFE_F00D;
    run(101);
    rst = 1'b1;
    step();
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frames", 64'(frames_sent), 64'd0);
    rst = 1'b0;
    debug_in = 64'h0102_0304_0506_0708;
    run_until_frames(16'd1, 2 * FRAME_CYC);

    prev = debug_in;
    for (int i = 0; i < 12000; i++) begin
      case ($urandom_range(0, 149))
        0: begin prev = debug_in; debug_in = {$urandom, $urandom}; end
        1: begin prev = debug_in; debug_in = 64'($urandom_range(0, 255)); end
        2: debug_in = prev;
        default: ;
      endcase
      send_req = ($urandom_range(0, 299) == 0);
      rst      = ($urandom_range(0, 4999) == 0);
      step();
    end
    send_req = 1'b0;
    rst      = 1'b0;
    begin
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 3 * FRAME_CYC) begin
        step();
        k++;
      end
      check("drain_idle", 64'(busy), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
